muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer placed beside the single-cycle ALU in the execute stage.
- Accepts one M-extension operation and drives a shared shift/add-subtract datapath for XLEN iterations.
- Stalls the pipeline while busy, then presents a one-cycle register write-back to exe_mem.
- The ALU result and this block's result are muxed by the exe stage on valid_o.

Parameters:
XLEN, 32, operand/result width
CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous, active-low reset
start_i  input  1  request a new operation; only sampled in IDLE
op_i  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
op1_i  input  XLEN  rs1 value
op2_i  input  XLEN  rs2 value
reg_waddr_i  input  5  destination register
flush_i  input  1  abort current operation (branch/trap flush)
stall_o  output  1  hold IF/ID/EXE stages
busy_o  output  1  state is not IDLE
valid_o  output  1  one-cycle result strobe
reg_we_o  output  1  write enable to exe_mem, equals valid_o
reg_waddr_o  output  5  latched destination
reg_wdata_o  output  XLEN  result

Behaviour:
- Reset (rst_i low, async): state IDLE, counter 0; all outputs 0; internal operand/accumulator registers 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start_i=1:
  - Latch op, reg_waddr, abs values of signed operands, and result-sign flags.
  - Signed operands: MULH both; MULHSU op1 only; DIV/REM both.
  - Go to CALC with counter=0.
- Special divides go to DONE directly, so valid_o is in cycle 1:
  - Divide-by-zero (op2=0): DIV/DIVU result 32'hFFFF_FFFF; REM/REMU result op1.
  - Signed overflow (DIV/REM, op1=32'h8000_0000, op2=32'hFFFF_FFFF): DIV result 32'h8000_0000; REM result 0.
- CALC, one iteration per cycle:
  - Multiply: shift-add into a 2*XLEN product.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - Counter increments each cycle; at counter=XLEN-1 go to FIX.
- FIX:
  - Apply two's-complement sign correction. Quotient sign = sign1^sign2; remainder sign = sign of dividend; product sign = xor of signed operands' signs.
  - Select result: MUL low word; MULH/MULHSU/MULHU high word; DIV/DIVU quotient; REM/REMU remainder.
  - Go to DONE.
- DONE: valid_o=reg_we_o=1 with result for exactly one cycle, then IDLE.
- Latency: start in cycle 0, CALC cycles 1..32, FIX cycle 33, valid_o in cycle 34.
- Outputs in non-DONE states: valid_o=0, reg_we_o=0, reg_wdata_o=0, reg_waddr_o=0.
- stall_o = (IDLE & start_i) | CALC | FIX. Combinational on start_i so the instruction is held the same cycle. Deasserted in DONE so the pipeline advances with the result.
- start_i while not IDLE: ignored.
- start_i in DONE: ignored; the requester re-presents the operation after return to IDLE.
- flush_i (synchronous) in any state: next state IDLE, no valid_o.
  - flush_i beats a simultaneous start_i in IDLE.
  - If in DONE, the strobe that cycle is suppressed.
- Reset mid-operation: immediate return to reset values, no strobe.
- Arithmetic: all internal adds XLEN+1 bits; results truncated to XLEN; no overflow flags.

Optional Feature:
- Macro MULDIV_ZERO_SKIP_EN.
- Defined: a multiply with op1=0 or op2=0 goes IDLE->DONE with result 0 (valid_o in cycle 1). A divide with op1=0 and op2!=0 goes IDLE->DONE with result 0.
- Undefined: these operations take the full 34-cycle path with identical results.

Test Plan:
- MUL 7 * -3 (op1=7, op2=32'hFFFF_FFFD, op_i=0), rd=5 -> stall_o high cycles 0..33; valid_o only in cycle 34, reg_wdata_o=32'hFFFF_FFEB, reg_waddr_o=5.
- MULH 32'h8000_0000 * 32'h8000_0000 -> 32'h4000_0000. MULHU 32'hFFFF_FFFF * 32'hFFFF_FFFF -> 32'hFFFF_FFFE. MULHSU -1 * 32'hFFFF_FFFF -> 32'hFFFF_FFFF.
- DIV -7/2 -> 32'hFFFF_FFFD; REM -7/2 -> 32'hFFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 32'hFFFF_FFFF and REM 5/0 -> 5, both valid in cycle 1. DIV 32'h8000_0000/-1 -> 32'h8000_0000, valid in cycle 1.
- Start DIVU, assert flush_i in cycle 10 -> busy_o=0 in cycle 11, no valid_o. A new start in cycle 12 completes normally in cycle 46.
- Pull rst_i low in cycle 20 of a MUL -> outputs 0 immediately, no strobe. Back-to-back starts held high during CALC -> only the first is accepted.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: one shift/add-subtract step per cycle.
// Optional MULDIV_ZERO_SKIP_EN: zero-operand multiplies and zero-dividend divides finish early.
module muldiv_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      reg_waddr_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic            reg_we_o,
  output logic [4:0]      reg_waddr_o,
  output logic [XLEN-1:0] reg_wdata_o
);

  localparam int unsigned    AW      = 2 * XLEN;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   res_q, res_d;

  // Operand decode for a new request
  logic            s1_signed, s2_signed, neg1, neg2;
  logic [XLEN-1:0] abs1, abs2;
  logic            div_zero, div_ovf, zero_skip;

  always_comb begin
    s1_signed = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
    s2_signed = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
    neg1      = s1_signed && op1_i[XLEN-1];
    neg2      = s2_signed && op2_i[XLEN-1];
    abs1      = neg1 ? (XLEN'(0) - op1_i) : op1_i;
    abs2      = neg2 ? (XLEN'(0) - op2_i) : op2_i;
    div_zero  = op_i[2] && (op2_i == '0);
    div_ovf   = ((op_i == 3'd4) || (op_i == 3'd6)) && (op1_i == MIN_NEG) && (op2_i == '1);
`ifdef MULDIV_ZERO_SKIP_EN
    zero_skip = (!op_i[2] && ((op1_i == '0) || (op2_i == '0))) ||
                (op_i[2] && (op1_i == '0) && (op2_i != '0));
`else
    zero_skip = 1'b0;
`endif
  end

  // One datapath iteration: acc holds {hi, lo} = {partial product, multiplier} or {remainder, quotient}
  logic [XLEN:0]   mul_sum, div_shl, div_diff;
  logic [AW-1:0]   mul_step, div_step;

  always_comb begin
    mul_sum  = acc_q[0] ? ({1'b0, acc_q[AW-1:XLEN]} + {1'b0, opb_q}) : {1'b0, acc_q[AW-1:XLEN]};
    mul_step = {mul_sum, acc_q[XLEN-1:1]};
    div_shl  = {acc_q[AW-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_shl - {1'b0, opb_q};
    if (!div_diff[XLEN]) begin
      div_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_step = {div_shl[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  // Sign correction and result select
  logic [AW-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = neg_q ? (AW'(0) - acc_q) : acc_q;
    quo_fix  = neg_q ? (XLEN'(0) - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_fix  = neg_q ? (XLEN'(0) - acc_q[AW-1:XLEN]) : acc_q[AW-1:XLEN];
    unique case (op_q)
      3'd0:                fix_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    fix_res = prod_fix[AW-1:XLEN];
      3'd4, 3'd5:          fix_res = quo_fix;
      default:             fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    waddr_d = waddr_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          waddr_d = reg_waddr_i;
          cnt_d   = '0;
          neg_d   = (op_i == 3'd6) ? neg1 : (neg1 ^ neg2);
          if (op_i[2]) begin
            opb_d = abs2;
            acc_d = {XLEN'(0), abs1};
          end else begin
            opb_d = abs1;
            acc_d = {XLEN'(0), abs2};
          end
          if (div_zero) begin
            res_d   = op_i[1] ? op1_i : '1;
            state_d = S_DONE;
          end else if (div_ovf) begin
            res_d   = op_i[1] ? '0 : MIN_NEG;
            state_d = S_DONE;
          end else if (zero_skip) begin
            res_d   = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = op_q[2] ? div_step : mul_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        res_d   = fix_res;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      waddr_q <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      waddr_q <= waddr_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  // Write-back strobe comes from registered state; a same-cycle flush suppresses it
  always_comb begin
    valid_o     = 1'b0;
    reg_we_o    = 1'b0;
    reg_waddr_o = '0;
    reg_wdata_o = '0;
    if ((state_q == S_DONE) && !flush_i) begin
      valid_o     = 1'b1;
      reg_we_o    = 1'b1;
      reg_waddr_o = waddr_q;
      reg_wdata_o = res_q;
    end
    busy_o  = (state_q != S_IDLE);
    stall_o = ((state_q == S_IDLE) && start_i) || (state_q == S_CALC) || (state_q == S_FIX);
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus randomized operations
// compared against an arithmetic reference model.
module tb_muldiv_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] op1_i, op2_i;
  logic [4:0]  reg_waddr_i;
  logic        flush_i;
  logic        stall_o, busy_o, valid_o, reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  muldiv_seq dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .op_i        (op_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .reg_waddr_i (reg_waddr_i),
    .flush_i     (flush_i),
    .stall_o     (stall_o),
    .busy_o      (busy_o),
    .valid_o     (valid_o),
    .reg_we_o    (reg_we_o),
    .reg_waddr_o (reg_waddr_o),
    .reg_wdata_o (reg_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Reference result from plain 64-bit arithmetic and the RV32M corner-case rules
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
        return 32'(sa / sb);
      end
      3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit s;
    s = (op[2] && b == 32'h0) ||
        ((op == 3'd4 || op == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF);
`ifdef MULDIV_ZERO_SKIP_EN
    s = s || (!op[2] && (a == 32'h0 || b == 32'h0)) || (op[2] && a == 32'h0 && b != 32'h0);
`endif
    return s;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return MIN_NEG;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation in the next cycle and follow it to completion, checking every cycle
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input bit hold, input bit flush_done);
    int lat;
    lat = is_special(op, a, b) ? 1 : 34;
    next_cycle();
    start_i = 1'b1; op_i = op; op1_i = a; op2_i = b; reg_waddr_i = rd;
    @(negedge clk_i);
    chk("start_stall", 32'(stall_o), 32'd1);
    chk("start_valid", 32'(valid_o), 32'd0);
    for (int c = 1; c <= lat; c++) begin
      next_cycle();
      start_i = hold;
      if (hold) begin
        op_i  = 3'($urandom_range(0, 7));
        op1_i = $urandom;
        op2_i = $urandom;
      end
      flush_i = flush_done && (c == lat);
      @(negedge clk_i);
      chk("busy", 32'(busy_o), 32'd1);
      if (c < lat) begin
        chk("stall_calc", 32'(stall_o), 32'd1);
        chk("valid_early", 32'(valid_o), 32'd0);
      end else if (flush_done) begin
        chk("valid_flushed", 32'(valid_o), 32'd0);
        chk("wdata_flushed", reg_wdata_o, 32'd0);
      end else begin
        chk("valid_done", 32'(valid_o), 32'd1);
        chk("we_done", 32'(reg_we_o), 32'd1);
        chk("waddr_done", 32'(reg_waddr_o), 32'(rd));
        chk("wdata_done", reg_wdata_o, exp);
        chk("stall_done", 32'(stall_o), 32'd0);
      end
    end
    next_cycle();
    start_i = 1'b0;
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("idle_valid", 32'(valid_o), 32'd0);
    chk("idle_waddr", 32'(reg_waddr_o), 32'd0);
    chk("idle_wdata", reg_wdata_o, 32'd0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    rst_i = 1'b0; start_i = 1'b0; op_i = 3'd0; op1_i = 32'h0; op2_i = 32'h0;
    reg_waddr_i = 5'd0; flush_i = 1'b0;
    #2;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_we", 32'(reg_we_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_wdata", reg_wdata_o, 32'd0);
    chk("rst_waddr", 32'(reg_waddr_o), 32'd0);
    #8 rst_i = 1'b1;

    // Directed arithmetic cases
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0, 1'b0);
    run_op(3'd1, MIN_NEG, MIN_NEG, 5'd1, 32'h4000_0000, 1'b0, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 1'b0, 1'b0);
    run_op(3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 1'b0, 1'b0);
    run_op(3'd4, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(3'd6, 32'd5, 32'd0, 5'd10, 32'd5, 1'b0, 1'b0);
    run_op(3'd4, MIN_NEG, 32'hFFFF_FFFF, 5'd11, MIN_NEG, 1'b0, 1'b0);
    run_op(3'd6, MIN_NEG, 32'hFFFF_FFFF, 5'd12, 32'd0, 1'b0, 1'b0);

    // Flush during CALC, then a fresh operation completes normally
    next_cycle();
    start_i = 1'b1; op_i = 3'd5; op1_i = 32'd1000; op2_i = 32'd3; reg_waddr_i = 5'd13;
    for (int c = 1; c <= 11; c++) begin
      next_cycle();
      start_i = 1'b0;
      flush_i = (c == 10);
      @(negedge clk_i);
      if (c == 10) chk("flush_valid", 32'(valid_o), 32'd0);
      if (c == 11) begin
        chk("flush_busy", 32'(busy_o), 32'd0);
        chk("flush_valid_after", 32'(valid_o), 32'd0);
      end
    end
    run_op(3'd5, 32'd1000, 32'd3, 5'd14, 32'd333, 1'b0, 1'b0);

    // Flush beats a simultaneous start in IDLE
    next_cycle();
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'd0; op1_i = 32'd3; op2_i = 32'd4;
    next_cycle();
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    chk("flush_start_busy", 32'(busy_o), 32'd0);

    // Flush on the DONE cycle suppresses the strobe
    run_op(3'd5, 32'd100, 32'd7, 5'd3, 32'd14, 1'b0, 1'b1);

    // Reset in cycle 20 of a multiply
    next_cycle();
    start_i = 1'b1; op_i = 3'd0; op1_i = 32'd12345; op2_i = 32'd678; reg_waddr_i = 5'd15;
    for (int c = 1; c <= 20; c++) begin
      next_cycle();
      start_i = 1'b0;
    end
    rst_i = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_valid", 32'(valid_o), 32'd0);
    chk("midrst_stall", 32'(stall_o), 32'd0);
    chk("midrst_wdata", reg_wdata_o, 32'd0);
    #2 rst_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      @(negedge clk_i);
      chk("postrst_valid", 32'(valid_o), 32'd0);
    end

    // Start held high throughout: only the first request is accepted
    run_op(3'd0, 32'd9, 32'd11, 5'd16, 32'd99, 1'b1, 1'b0);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick();
      rb  = pick();
      run_op(rop, ra, rb, 5'($urandom_range(0, 31)), ref_model(rop, ra, rb), (i % 8) == 3, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
